// File: rtl/cadena_pkg.sv
// cadena_pkg: shared widths, pointer steps and state encoding for the string-move sequencer
package cadena_pkg;
  localparam int ANCHO     = 16;
  localparam int PASO_BYTE = 1;
  localparam int PASO_WORD = 2;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    READ   = 3'd2,
    WRITE  = 3'd3,
    UPDATE = 3'd4,
    FINISH = 3'd5
  } estado_t;
endpackage

// File: rtl/paso_puntero.sv
// paso_puntero: advances a pointer by a byte or word step in either direction, wrapping modulo 2^ANCHO
module paso_puntero #(
  parameter int ANCHO     = cadena_pkg::ANCHO,
  parameter int PASO_BYTE = cadena_pkg::PASO_BYTE,
  parameter int PASO_WORD = cadena_pkg::PASO_WORD
) (
  input  logic [ANCHO-1:0] val_i,
  input  logic             word_i,
  input  logic             df_i,
  output logic [ANCHO-1:0] res_o
);
  logic [ANCHO-1:0] paso;
  assign paso  = word_i ? ANCHO'(PASO_WORD) : ANCHO'(PASO_BYTE);
  assign res_o = df_i ? val_i - paso : val_i + paso;
endmodule

// File: rtl/secuenciador_cadena.sv
// secuenciador_cadena: copies [SI] to [DI] once or while CX!=0, driving the memory port and
// the SI/DI/CX load strobes from registered outputs.
module secuenciador_cadena #(
  parameter int ANCHO     = cadena_pkg::ANCHO,
  parameter int PASO_BYTE = cadena_pkg::PASO_BYTE,
  parameter int PASO_WORD = cadena_pkg::PASO_WORD
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             REP,
  input  logic             WORD,
  input  logic             DF,
  input  logic [ANCHO-1:0] SI_IN,
  input  logic [ANCHO-1:0] DI_IN,
  input  logic [ANCHO-1:0] CX_IN,
  output logic             MEM_RD_REQ,
  output logic             MEM_WR_REQ,
  output logic [ANCHO-1:0] MEM_ADDR,
  output logic [ANCHO-1:0] MEM_WDATA,
  input  logic [ANCHO-1:0] MEM_RDATA,
  input  logic             MEM_ACK,
  output logic             SI_ENA,
  output logic             DI_ENA,
  output logic             CX_ENA,
  output logic [ANCHO-1:0] SI_D,
  output logic [ANCHO-1:0] DI_D,
  output logic [ANCHO-1:0] CX_D,
  output logic             BUSY,
  output logic             DONE
);
  import cadena_pkg::*;
  estado_t          state_q, state_d;
  logic [ANCHO-1:0] si_q, si_d, di_q, di_d, cx_q, cx_d, dato_q, dato_d;
  logic [ANCHO-1:0] si_nx, di_nx, cx_nx;
  logic             rep_q, rep_d, word_q, word_d, df_q, df_d, upd;
  logic             rd_q, wr_q, si_ena_q, di_ena_q, cx_ena_q, busy_q, done_q;
  logic [ANCHO-1:0] addr_q, sid_q, did_q, cxd_q;
  paso_puntero #(.ANCHO(ANCHO), .PASO_BYTE(PASO_BYTE), .PASO_WORD(PASO_WORD)) u_si (
    .val_i(si_q), .word_i(word_q), .df_i(df_q), .res_o(si_nx)
  );
  paso_puntero #(.ANCHO(ANCHO), .PASO_BYTE(PASO_BYTE), .PASO_WORD(PASO_WORD)) u_di (
    .val_i(di_q), .word_i(word_q), .df_i(df_q), .res_o(di_nx)
  );
  assign cx_nx = cx_q - ANCHO'(1);
  assign upd   = state_d == UPDATE;
  always_comb begin
    state_d = state_q;
    si_d    = si_q;
    di_d    = di_q;
    cx_d    = cx_q;
    dato_d  = dato_q;
    rep_d   = rep_q;
    word_d  = word_q;
    df_d    = df_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = CHECK;
        si_d    = SI_IN;
        di_d    = DI_IN;
        cx_d    = CX_IN;
        rep_d   = REP;
        word_d  = WORD;
        df_d    = DF;
      end
      CHECK: state_d = (rep_q && cx_q == '0) ? FINISH : READ;
      READ: if (MEM_ACK) begin
        dato_d  = MEM_RDATA;
        state_d = WRITE;
      end
      WRITE: state_d = MEM_ACK ? UPDATE : WRITE;
      UPDATE: begin
        si_d    = si_nx;
        di_d    = di_nx;
        cx_d    = rep_q ? cx_nx : cx_q;
        state_d = rep_q ? CHECK : FINISH;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they are flops aligned with the state they belong to.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      si_q     <= '0;
      di_q     <= '0;
      cx_q     <= '0;
      dato_q   <= '0;
      rep_q    <= 1'b0;
      word_q   <= 1'b0;
      df_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      si_ena_q <= 1'b0;
      di_ena_q <= 1'b0;
      cx_ena_q <= 1'b0;
      sid_q    <= '0;
      did_q    <= '0;
      cxd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      si_q     <= si_d;
      di_q     <= di_d;
      cx_q     <= cx_d;
      dato_q   <= dato_d;
      rep_q    <= rep_d;
      word_q   <= word_d;
      df_q     <= df_d;
      rd_q     <= state_d == READ;
      wr_q     <= state_d == WRITE;
      addr_q   <= state_d == READ ? si_d : state_d == WRITE ? di_d : '0;
      si_ena_q <= upd;
      di_ena_q <= upd;
      cx_ena_q <= upd && rep_q;
      sid_q    <= upd ? si_nx : sid_q;
      did_q    <= upd ? di_nx : did_q;
      cxd_q    <= upd && rep_q ? cx_nx : cxd_q;
      busy_q   <= state_d != IDLE;
      done_q   <= state_d == FINISH;
    end
  end
  assign MEM_RD_REQ = rd_q;
  assign MEM_WR_REQ = wr_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_WDATA  = dato_q;
  assign SI_ENA     = si_ena_q;
  assign DI_ENA     = di_ena_q;
  assign CX_ENA     = cx_ena_q;
  assign SI_D       = sid_q;
  assign DI_D       = did_q;
  assign CX_D       = cxd_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
endmodule

// File: tb/tb_secuenciador_cadena.sv
// tb_secuenciador_cadena: scoreboard bench; directed moves queue their expected events, a monitor pops them.
module tb_secuenciador_cadena;
  localparam int K_RD = 0, K_WR = 1, K_SI = 2, K_DI = 3, K_CX = 4, K_DN = 5;
  typedef struct {int k; logic [15:0] a; logic [15:0] b;} ev_t;
  logic CLK = 0, RST_N = 0, START = 0, REP = 0, WORD = 0, DF = 0, MEM_ACK = 0;
  logic [15:0] SI_IN = 0, DI_IN = 0, CX_IN = 0, MEM_RDATA = 0;
  logic MEM_RD_REQ, MEM_WR_REQ, SI_ENA, DI_ENA, CX_ENA, BUSY, DONE;
  logic [15:0] MEM_ADDR, MEM_WDATA, SI_D, DI_D, CX_D;
  ev_t q[$];
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, rd_wait = 0, wr_wait = 0, wcnt = 0;
  bit done_seen = 0, prd = 0, pwr = 0;
  logic [15:0] rdata_v = 0, paddr = 0, pdata = 0;

  secuenciador_cadena dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .REP(REP), .WORD(WORD), .DF(DF),
    .SI_IN(SI_IN), .DI_IN(DI_IN), .CX_IN(CX_IN),
    .MEM_RD_REQ(MEM_RD_REQ), .MEM_WR_REQ(MEM_WR_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .SI_ENA(SI_ENA), .DI_ENA(DI_ENA), .CX_ENA(CX_ENA),
    .SI_D(SI_D), .DI_D(DI_D), .CX_D(CX_D), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Memory responder: acknowledges after rd_wait / wr_wait idle request cycles.
  always @(negedge CLK) begin
    if (MEM_RD_REQ || MEM_WR_REQ) begin
      MEM_ACK   = (wcnt == (MEM_RD_REQ ? rd_wait : wr_wait));
      MEM_RDATA = (MEM_ACK && MEM_RD_REQ) ? rdata_v : 16'h0;
      wcnt      = MEM_ACK ? 0 : wcnt + 1;
    end else begin
      MEM_ACK = 0;
      wcnt    = 0;
    end
  end

  task automatic push(input int k, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    e.k = k; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic expect_ev(input int k, input logic [15:0] a, input logic [15:0] b, input string nm);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected: got kind=%0d a=%h b=%h, required no event", nm, k, a, b);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.a != a || e.b != b) begin
        errors++;
        $display("FAIL %s: got kind=%0d a=%h b=%h, required kind=%0d a=%h b=%h", nm, k, a, b, e.k, e.a, e.b);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (MEM_RD_REQ && MEM_WR_REQ) begin
        checks++; errors++;
        $display("FAIL req_excl: got rd=1 wr=1, required at most one");
      end
      if (MEM_RD_REQ) begin
        if (!prd) expect_ev(K_RD, MEM_ADDR, 16'h0, "read");
        else chk("read_hold_addr", MEM_ADDR, paddr);
      end
      if (MEM_WR_REQ) begin
        if (!pwr) expect_ev(K_WR, MEM_ADDR, MEM_WDATA, "write");
        else begin
          chk("write_hold_addr", MEM_ADDR, paddr);
          chk("write_hold_data", MEM_WDATA, pdata);
        end
      end
      if (SI_ENA) expect_ev(K_SI, SI_D, 16'h0, "si_load");
      if (DI_ENA) expect_ev(K_DI, DI_D, 16'h0, "di_load");
      if (CX_ENA) expect_ev(K_CX, CX_D, 16'h0, "cx_load");
      if (DONE) begin
        expect_ev(K_DN, 16'(cyc - start_cyc), 16'h0, "done_latency");
        done_seen = 1;
      end
      prd = MEM_RD_REQ; pwr = MEM_WR_REQ; paddr = MEM_ADDR; pdata = MEM_WDATA;
    end else begin
      prd = 0; pwr = 0;
    end
  end

  task automatic launch(input logic [15:0] si, input logic [15:0] di, input logic [15:0] cx,
                        input logic rep, input logic word, input logic df);
    @(negedge CLK);
    SI_IN = si; DI_IN = di; CX_IN = cx; REP = rep; WORD = word; DF = df;
    START = 1; start_cyc = cyc; done_seen = 0;
    @(negedge CLK);
    START = 0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 200 && !done_seen; i++) begin
      @(negedge CLK); #1;
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s timeout: got no DONE, required DONE within 200 cycles", nm);
    end
    repeat (3) @(negedge CLK);
    #1;
    chk({nm, "_idle"}, {15'h0, BUSY}, 16'h0);
    chk({nm, "_drained"}, 16'(q.size()), 16'h0);
  endtask

  initial begin
    #1;
    chk("rst_rd", {15'h0, MEM_RD_REQ}, 16'h0);
    chk("rst_wr", {15'h0, MEM_WR_REQ}, 16'h0);
    chk("rst_addr", MEM_ADDR, 16'h0);
    chk("rst_wdata", MEM_WDATA, 16'h0);
    chk("rst_ena", {13'h0, SI_ENA, DI_ENA, CX_ENA}, 16'h0);
    chk("rst_busy_done", {14'h0, BUSY, DONE}, 16'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1;

    // single byte move, increment
    rdata_v = 16'h00AB;
    push(K_RD, 16'h0100, 0); push(K_WR, 16'h0200, 16'h00AB);
    push(K_SI, 16'h0101, 0); push(K_DI, 16'h0201, 0); push(K_DN, 16'd5, 0);
    launch(16'h0100, 16'h0200, 16'h0009, 0, 0, 0);
    wait_done("single_byte");

    // REP word, decrement, CX=3
    rdata_v = 16'h1234;
    push(K_RD, 16'h1000, 0); push(K_WR, 16'h2000, 16'h1234);
    push(K_SI, 16'h0FFE, 0); push(K_DI, 16'h1FFE, 0); push(K_CX, 16'd2, 0);
    push(K_RD, 16'h0FFE, 0); push(K_WR, 16'h1FFE, 16'h1234);
    push(K_SI, 16'h0FFC, 0); push(K_DI, 16'h1FFC, 0); push(K_CX, 16'd1, 0);
    push(K_RD, 16'h0FFC, 0); push(K_WR, 16'h1FFC, 16'h1234);
    push(K_SI, 16'h0FFA, 0); push(K_DI, 16'h1FFA, 0); push(K_CX, 16'd0, 0);
    push(K_DN, 16'd14, 0);
    launch(16'h1000, 16'h2000, 16'd3, 1, 1, 1);
    wait_done("rep_word_dec");

    // REP with CX=0: no memory traffic, no strobes
    push(K_DN, 16'd2, 0);
    launch(16'h4000, 16'h5000, 16'd0, 1, 1, 0);
    wait_done("rep_cx0");

    // wrap-around byte increment
    rdata_v = 16'h00C3;
    push(K_RD, 16'hFFFF, 0); push(K_WR, 16'hFFFE, 16'h00C3);
    push(K_SI, 16'h0000, 0); push(K_DI, 16'hFFFF, 0); push(K_DN, 16'd5, 0);
    launch(16'hFFFF, 16'hFFFE, 16'd0, 0, 0, 0);
    wait_done("wrap");

    // wait states, plus a START pulse while busy that must be ignored
    rd_wait = 3; wr_wait = 2; rdata_v = 16'hBEEF;
    push(K_RD, 16'h0010, 0); push(K_WR, 16'h0020, 16'hBEEF);
    push(K_SI, 16'h0012, 0); push(K_DI, 16'h0022, 0); push(K_DN, 16'd10, 0);
    launch(16'h0010, 16'h0020, 16'd0, 0, 1, 0);
    @(negedge CLK);
    SI_IN = 16'h7777; DI_IN = 16'h8888; CX_IN = 16'd5; REP = 1; START = 1;
    @(negedge CLK);
    START = 0;
    wait_done("wait_states");

    // reset while a write is pending
    rd_wait = 0; wr_wait = 6; rdata_v = 16'h5555;
    push(K_RD, 16'h0300, 0); push(K_WR, 16'h0400, 16'h5555);
    launch(16'h0300, 16'h0400, 16'd0, 0, 0, 0);
    for (int i = 0; i < 20 && !MEM_WR_REQ; i++) begin
      @(negedge CLK); #1;
    end
    chk("reach_write", {15'h0, MEM_WR_REQ}, 16'h1);
    RST_N = 0;
    #1;
    chk("mid_rst_wr", {15'h0, MEM_WR_REQ}, 16'h0);
    chk("mid_rst_busy", {15'h0, BUSY}, 16'h0);
    chk("mid_rst_addr", MEM_ADDR, 16'h0);
    chk("mid_rst_ena", {13'h0, SI_ENA, DI_ENA, CX_ENA}, 16'h0);
    @(negedge CLK);
    RST_N = 1;
    repeat (6) @(negedge CLK);
    #1;
    chk("post_rst_busy", {15'h0, BUSY}, 16'h0);
    chk("post_rst_no_done", {15'h0, done_seen}, 16'h0);
    chk("post_rst_drained", 16'(q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
